// File: rtl/mult_accum_unit_if.sv
// mult_accum_unit_if: operand and result bundle for the multiply-accumulate unit
interface mult_accum_unit_if #(
    parameter int A_WIDTH   = 9,
    parameter int B_WIDTH   = 9,
    parameter int RES_WIDTH = 18
);
    logic signed [A_WIDTH-1:0]   dataa;
    logic signed [B_WIDTH-1:0]   datab;
    logic signed [RES_WIDTH-1:0] result;
    modport master (output dataa, output datab, input result);
    modport slave  (input dataa, input datab, output result);
endinterface

// File: rtl/mult_accum_unit.sv
// mult_accum_unit: 3-stage signed multiply-accumulate (operand regs, product reg, accumulator)
module mult_accum_unit #(
    parameter int A_WIDTH   = 9,
    parameter int B_WIDTH   = 9,
    parameter int RES_WIDTH = 18
) (
    input logic clock0,
    input logic aclr0,
    mult_accum_unit_if.slave bus
);
    logic signed [A_WIDTH-1:0]   r_a;
    logic signed [B_WIDTH-1:0]   r_b;
    logic signed [RES_WIDTH-1:0] r_p;
    logic signed [RES_WIDTH-1:0] r_acc;
    logic signed [RES_WIDTH-1:0] w_a;
    logic signed [RES_WIDTH-1:0] w_b;
    // operands widened first so the product is exact in RES_WIDTH
    assign w_a = RES_WIDTH'(r_a);
    assign w_b = RES_WIDTH'(r_b);
    always_ff @(posedge clock0) begin
        if (aclr0) begin
            r_a   <= '0;
            r_b   <= '0;
            r_p   <= '0;
            r_acc <= '0;
        end else begin
            r_a   <= bus.dataa;
            r_b   <= bus.datab;
            r_p   <= w_a * w_b;
            r_acc <= r_acc + r_p;
        end
    end
    assign bus.result = r_acc;
endmodule

// File: tb/tb_mult_accum_unit.sv
// tb_mult_accum_unit: directed and random scoreboard checks of the MAC pipeline
module tb_mult_accum_unit;
    typedef struct {
        string       name;
        logic [17:0] v;
    } exp_t;

    logic clock0 = 1'b0;
    logic aclr0  = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    int   m_a = 0, m_b = 0;
    logic [17:0] m_p = '0, m_acc = '0;

    mult_accum_unit_if #(.A_WIDTH(9), .B_WIDTH(9), .RES_WIDTH(18)) bus ();
    mult_accum_unit #(.A_WIDTH(9), .B_WIDTH(9), .RES_WIDTH(18)) dut (
        .clock0(clock0),
        .aclr0 (aclr0),
        .bus   (bus)
    );

    always #5 clock0 = ~clock0;

    // one edge of stimulus; the reference pipe always advances, but directed
    // steps push the hand-computed value instead of the model's
    task automatic step(input string name, input bit clr, input int a, input int b,
                        input bit use_m, input int exp);
        exp_t e;
        aclr0 = clr;
        bus.dataa = 9'(a);
        bus.datab = 9'(b);
        @(posedge clock0);
        if (clr) begin
            m_a = 0; m_b = 0; m_p = '0; m_acc = '0;
        end else begin
            m_acc = m_acc + m_p;
            m_p   = 18'(m_a * m_b);
            m_a   = a;
            m_b   = b;
        end
        e.name = name;
        e.v    = use_m ? m_acc : 18'(exp);
        q.push_back(e);
        @(negedge clock0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock0);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (bus.result !== e.v) begin
                    failures++;
                    $display("FAIL %s: result=%0d (0x%05h) expected=%0d (0x%05h)",
                             e.name, $signed(bus.result), bus.result, $signed(e.v), e.v);
                end
            end
        end
    end

    initial begin : stim
        int a, b;
        bit clr;
        bus.dataa = '0;
        bus.datab = '0;
        @(negedge clock0);
        step("reset", 1, 0, 0, 0, 0);
        step("reset", 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("hold", 0, 0, 0, 0, 0);

        step("mac_clr", 1, 0, 0, 0, 0);
        step("mac", 0, 3, 4, 0, 0);
        step("mac", 0, 3, 4, 0, 0);
        step("mac", 0, 3, 4, 0, 12);
        step("mac", 0, 3, 4, 0, 24);
        step("mac", 0, 3, 4, 0, 36);

        step("sgn_clr", 1, 0, 0, 0, 0);
        step("sgn", 0, -5, 7, 0, 0);
        step("sgn", 0, 0, 0, 0, 0);
        step("sgn", 0, 0, 0, 0, -35);
        step("sgn", 0, 0, 0, 0, -35);
        step("sgn", 0, 0, 0, 0, -35);

        step("ext_clr", 1, 0, 0, 0, 0);
        step("ext", 0, -256, -256, 0, 0);
        step("ext", 0, 255, -256, 0, 0);
        step("ext", 0, 0, 0, 0, 65536);
        step("ext", 0, 0, 0, 0, 256);

        step("wrap_clr", 1, 0, 0, 0, 0);
        step("wrap", 0, 255, 255, 0, 0);
        step("wrap", 0, 255, 255, 0, 0);
        step("wrap", 0, 255, 255, 0, 65025);
        step("wrap", 0, 255, 255, 0, 130050);
        step("wrap", 0, 255, 255, 0, -67069);

        step("mid_clr0", 1, 0, 0, 0, 0);
        step("mid", 0, 2, 5, 0, 0);
        step("mid", 0, 2, 5, 0, 0);
        step("mid", 0, 2, 5, 0, 10);
        step("mid", 0, 2, 5, 0, 20);
        step("mid", 0, 2, 5, 0, 30);
        step("mid_clr", 1, 2, 5, 0, 0);
        step("mid_c1", 0, 2, 5, 0, 0);
        step("mid_c2", 0, 2, 5, 0, 0);
        step("mid_c3", 0, 2, 5, 0, 10);
        step("mid_c4", 0, 2, 5, 0, 20);

        step("rnd_clr", 1, 0, 0, 0, 0);
        clr = 0;
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, 18)) - 9;
            b = int'($urandom_range(0, 18)) - 9;
            step("rnd", clr, a, b, 1, 0);
            clr = (a == 9);
        end
        step("rnd_tail", 0, 0, 0, 1, 0);
        step("rnd_tail", 0, 0, 0, 1, 0);
        step("rnd_tail", 0, 0, 0, 1, 0);

        repeat (2) @(negedge clock0);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
